mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DM_WORDS, default 1024, data memory depth in 32-bit words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 RegWriteE  input  1  E/M-registered register-write enable.
REQ-005 SDtoRegE  input  2  E/M-registered writeback select: 0 = ALU, 1 = memory, 2 = PC+8.
REQ-006 MemWriteE  input  1  E/M-registered store enable.
REQ-007 ALUOutE  input  32  E/M-registered ALU result, also the byte address.
REQ-008 WriteDataE  input  32  E/M-registered store data.
REQ-009 WriteRegE  input  5  E/M-registered destination register.
REQ-010 rtE  input  5  rt field of the instruction in M, used for store-data forwarding.
REQ-011 dPCE, dInstrE  input  32 each  PC and instruction word of the instruction in M.
REQ-012 WriteRegW, RegWriteW  input  5/1  destination and write enable of the instruction in W.
REQ-013 ResultW  input  32  final writeback value of the instruction in W.
REQ-014 RegWriteM, SDtoRegM, WriteRegM  output  1/2/5  M/W-registered copies of the control inputs.
REQ-015 ALUOutM, ReadDataM  output  32 each  M/W-registered ALU result and load data.
REQ-016 dPCM, dInstrM  output  32 each  M/W-registered PC and instruction word.

Function
REQ-017 Memory array SHALL be DM_WORDS x 32 bits, word-indexed by ALUOutE[11:2]; ALUOutE[1:0] ignored; higher address bits ignored, so addresses wrap modulo 4 KiB.
REQ-018 Store data SHALL be forwarded:
- use ResultW when RegWriteW=1, WriteRegW==rtE and rtE!=0;
- otherwise use WriteDataE.
REQ-019 When MemWriteE=1 and reset=0, the array word SHALL take the forwarded store data at the rising edge.
REQ-020 Read SHALL be combinational from the array at ALUOutE[11:2] and registered into ReadDataM at the same edge.
- A same-cycle store to the same word reads the pre-store value.
REQ-021 A load issued in the cycle after a store to the same word SHALL return the stored value.
REQ-022 Every completed store SHALL print one simulation line "@<dPCE hex>: *<word-aligned address hex> <= <data hex>" at the storing edge.
REQ-023 M/W register SHALL have latency 1 cycle. Each edge without reset:
- XxxM <= XxxE for RegWrite, SDtoReg, WriteReg, ALUOut;
- dPCM <= dPCE; dInstrM <= dInstrE.
REQ-024 RegWriteM SHALL be forced to 0 when WriteRegE==0, so register 0 is never reported as a forwarding source.
REQ-025 No stall or flush input SHALL exist; the block advances every cycle.

Reset
REQ-026 With reset=1 at a rising edge, all M/W outputs SHALL become 0 and every memory word SHALL become 0.
REQ-027 A store presented in the same cycle as reset SHALL be discarded; no display line is printed.
REQ-028 After reset deasserts, the first edge SHALL capture inputs normally.

Verification
REQ-029 Store then load: store data 0x12345678 at address 0x10; next cycle load 0x10 -> ReadDataM=0x12345678 and SDtoRegM=1 one edge later; one display line "@<pc>: *00000010 <= 12345678".
REQ-030 W-stage forwarding: WriteDataE=0x1, rtE=8, WriteRegW=8, RegWriteW=1, ResultW=0xCAFE0000, store to 0x20 -> mem[0x20]=0xCAFE0000. Repeat with rtE=0 -> stored value 0x1.
REQ-031 Same-cycle read/write: mem[0x4]=0xAA; store 0xBB to 0x4 -> ReadDataM=0xAA that edge; load 0x4 next cycle -> 0xBB.
REQ-032 Alignment and wrap:
- store 0x55 at 0x1003 -> a load from 0x0 returns 0x55;
- a load from 0x1000 returns 0x55.
REQ-033 Reset mid-operation: with MemWriteE=1 at address 0x8 and reset=1 -> mem[0x8]=0 and all outputs 0; a load from 0x8 after reset returns 0.
REQ-034 Register-0 suppression: RegWriteE=1 with WriteRegE=0 -> RegWriteM=0.
- A jal pass-through (SDtoRegE=2, WriteRegE=31, dPCE=0x3000) -> SDtoRegM=2, WriteRegM=31, dPCM=0x3000 after one edge.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bus between the E/M pipeline register side and the memory stage.
// The master drives the E-side (instruction entering M) and the W-side
// forwarding source, and receives the M/W-registered outputs; the slave
// (mem_stage) does the opposite. There is no valid/ready handshake: the
// stage advances every clock, so every signal is sampled at each rising
// edge and the M outputs change only at rising edges.
interface mem_stage_if;
  // Instruction entering the memory stage (E/M-registered)
  logic        RegWriteE;
  logic [1:0]  SDtoRegE;
  logic        MemWriteE;
  logic [31:0] ALUOutE;
  logic [31:0] WriteDataE;
  logic [4:0]  WriteRegE;
  logic [4:0]  rtE;
  logic [31:0] dPCE;
  logic [31:0] dInstrE;

  // Instruction in writeback, used as the store-data forwarding source
  logic [4:0]  WriteRegW;
  logic        RegWriteW;
  logic [31:0] ResultW;

  // M/W-registered outputs
  logic        RegWriteM;
  logic [1:0]  SDtoRegM;
  logic [4:0]  WriteRegM;
  logic [31:0] ALUOutM;
  logic [31:0] ReadDataM;
  logic [31:0] dPCM;
  logic [31:0] dInstrM;

  modport master (
    output RegWriteE, SDtoRegE, MemWriteE, ALUOutE, WriteDataE, WriteRegE,
           rtE, dPCE, dInstrE, WriteRegW, RegWriteW, ResultW,
    input  RegWriteM, SDtoRegM, WriteRegM, ALUOutM, ReadDataM, dPCM, dInstrM
  );

  modport slave (
    input  RegWriteE, SDtoRegE, MemWriteE, ALUOutE, WriteDataE, WriteRegE,
           rtE, dPCE, dInstrE, WriteRegW, RegWriteW, ResultW,
    output RegWriteM, SDtoRegM, WriteRegM, ALUOutM, ReadDataM, dPCM, dInstrM
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage of a 5-stage pipeline: word-addressed data memory with
// W-stage store-data forwarding, plus the M/W pipeline register.
// The array reads combinationally and the result is captured into
// ReadDataM at the same edge that may also write the array, so a store and
// a load to the same word in one cycle return the old contents, and a load
// in the following cycle sees the new contents.
module mem_stage #(
  parameter int DM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  // Word index width; with the default depth this selects ALUOutE[11:2],
  // so byte offsets are dropped and addresses wrap every 4 KiB.
  localparam int AW = $clog2(DM_WORDS);

  // Data memory
  logic [31:0] mem_q [DM_WORDS];

  // Pipeline register state
  logic        regwrite_q, regwrite_d;
  logic [1:0]  sdtoreg_q,  sdtoreg_d;
  logic [4:0]  writereg_q, writereg_d;
  logic [31:0] aluout_q,   aluout_d;
  logic [31:0] readdata_q, readdata_d;
  logic [31:0] dpc_q,      dpc_d;
  logic [31:0] dinstr_q,   dinstr_d;

  // Address decode, forwarding and read data
  logic [AW-1:0] word_idx;
  logic          fwd_hit;
  logic [31:0]   store_data;
  logic [31:0]   rd_data;
  logic          do_store;

  assign word_idx = bus.ALUOutE[AW+1:2];

  // Forward the W-stage result when it targets the store's rt register;
  // register 0 is never a forwarding source.
  assign fwd_hit    = bus.RegWriteW && (bus.WriteRegW == bus.rtE) && (bus.rtE != 5'd0);
  assign store_data = fwd_hit ? bus.ResultW : bus.WriteDataE;

  assign rd_data  = mem_q[word_idx];
  assign do_store = bus.MemWriteE && !reset;

  // Next-state values of the M/W register
  always_comb begin
    regwrite_d = bus.RegWriteE && (bus.WriteRegE != 5'd0);
    sdtoreg_d  = bus.SDtoRegE;
    writereg_d = bus.WriteRegE;
    aluout_d   = bus.ALUOutE;
    readdata_d = rd_data;
    dpc_d      = bus.dPCE;
    dinstr_d   = bus.dInstrE;
  end

  // M/W register: clears on reset, otherwise captures every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      sdtoreg_q  <= 2'd0;
      writereg_q <= 5'd0;
      aluout_q   <= 32'd0;
      readdata_q <= 32'd0;
      dpc_q      <= 32'd0;
      dinstr_q   <= 32'd0;
    end else begin
      regwrite_q <= regwrite_d;
      sdtoreg_q  <= sdtoreg_d;
      writereg_q <= writereg_d;
      aluout_q   <= aluout_d;
      readdata_q <= readdata_d;
      dpc_q      <= dpc_d;
      dinstr_q   <= dinstr_d;
    end
  end

  // Data memory: reset clears every word and discards a pending store
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (do_store) begin
      mem_q[word_idx] <= store_data;
    end
  end

`ifndef SYNTHESIS
  // Store trace, one line per committed store
  always @(posedge clk) begin
    if (do_store) begin
      $display("@%h: *%h <= %h", bus.dPCE, {bus.ALUOutE[31:2], 2'b00}, store_data);
    end
  end
`endif

  assign bus.RegWriteM = regwrite_q;
  assign bus.SDtoRegM  = sdtoreg_q;
  assign bus.WriteRegM = writereg_q;
  assign bus.ALUOutM   = aluout_q;
  assign bus.ReadDataM = readdata_q;
  assign bus.dPCM      = dpc_q;
  assign bus.dInstrM   = dinstr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed steps followed by a short random run.
// Each step pushes the expected M-side output vector when inputs are
// applied and pops/compares it one edge later; directed constant checks
// cover the named scenarios.
module tb_mem_stage;
  localparam int W = 136;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_if bus();

  mem_stage #(.DM_WORDS(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  logic [31:0]  model_mem [0:1023];
  int checks = 0;
  int errors = 0;

  function automatic logic [W-1:0] obs_vec();
    return {bus.RegWriteM, bus.SDtoRegM, bus.WriteRegM, bus.ALUOutM,
            bus.ReadDataM, bus.dPCM, bus.dInstrM};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_idle();
    reset          = 1'b0;
    bus.RegWriteE  = 1'b0;
    bus.SDtoRegE   = 2'd0;
    bus.MemWriteE  = 1'b0;
    bus.ALUOutE    = 32'd0;
    bus.WriteDataE = 32'd0;
    bus.WriteRegE  = 5'd0;
    bus.rtE        = 5'd0;
    bus.dPCE       = 32'd0;
    bus.dInstrE    = 32'd0;
    bus.WriteRegW  = 5'd0;
    bus.RegWriteW  = 1'b0;
    bus.ResultW    = 32'd0;
  endtask

  task automatic set_store(input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] rt, input logic [31:0] pc);
    set_idle();
    bus.MemWriteE  = 1'b1;
    bus.ALUOutE    = addr;
    bus.WriteDataE = data;
    bus.rtE        = rt;
    bus.dPCE       = pc;
    bus.dInstrE    = 32'hAC000000 | {11'd0, rt, 16'd0};
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] pc);
    set_idle();
    bus.RegWriteE = 1'b1;
    bus.SDtoRegE  = 2'd1;
    bus.ALUOutE   = addr;
    bus.WriteRegE = rd;
    bus.dPCE      = pc;
    bus.dInstrE   = 32'h8C000000 | {11'd0, rd, 16'd0};
  endtask

  // Apply current inputs for one edge: model, push, clock, pop, compare
  task automatic step(input string tag);
    logic [W-1:0] e;
    logic [31:0]  rd;
    logic [31:0]  fwd;
    int           idx;
    if (reset) begin
      for (int i = 0; i < 1024; i++) model_mem[i] = 32'd0;
      e = '0;
    end else begin
      idx = int'(bus.ALUOutE[11:2]);
      rd  = model_mem[idx];
      if (bus.RegWriteW && bus.WriteRegW == bus.rtE && bus.rtE != 5'd0) fwd = bus.ResultW;
      else fwd = bus.WriteDataE;
      if (bus.MemWriteE) model_mem[idx] = fwd;
      e = {bus.RegWriteE && (bus.WriteRegE != 5'd0), bus.SDtoRegE, bus.WriteRegE,
           bus.ALUOutE, rd, bus.dPCE, bus.dInstrE};
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag, obs_vec(), exp_q.pop_front());
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'd0;
    set_idle();

    // Reset state
    reset = 1'b1;
    step("reset0");
    step("reset1");
    check("reset_aluout", {104'd0, bus.ALUOutM}, '0);

    // Store then load
    set_store(32'h10, 32'h12345678, 5'd9, 32'h400);
    step("st_10");
    set_load(32'h10, 5'd2, 32'h404);
    step("ld_10");
    check("ld_10_data", {104'd0, bus.ReadDataM}, {104'd0, 32'h12345678});
    check("ld_10_sel", {134'd0, bus.SDtoRegM}, {134'd0, 2'd1});

    // W-stage forwarding hit
    set_store(32'h20, 32'h1, 5'd8, 32'h408);
    bus.WriteRegW = 5'd8; bus.RegWriteW = 1'b1; bus.ResultW = 32'hCAFE0000;
    step("st_fwd");
    set_load(32'h20, 5'd3, 32'h40C);
    step("ld_fwd");
    check("fwd_data", {104'd0, bus.ReadDataM}, {104'd0, 32'hCAFE0000});
    // rt = 0 never forwards
    set_store(32'h20, 32'h1, 5'd0, 32'h410);
    bus.WriteRegW = 5'd0; bus.RegWriteW = 1'b1; bus.ResultW = 32'hCAFE0000;
    step("st_rt0");
    set_load(32'h20, 5'd3, 32'h414);
    step("ld_rt0");
    check("rt0_data", {104'd0, bus.ReadDataM}, {104'd0, 32'h1});
    // Matching register but W not writing
    set_store(32'h24, 32'h2, 5'd8, 32'h418);
    bus.WriteRegW = 5'd8; bus.RegWriteW = 1'b0; bus.ResultW = 32'hDEAD0000;
    step("st_nowr");
    set_load(32'h24, 5'd3, 32'h41C);
    step("ld_nowr");
    check("nowr_data", {104'd0, bus.ReadDataM}, {104'd0, 32'h2});

    // Same-cycle read/write
    set_store(32'h4, 32'hAA, 5'd4, 32'h500);
    step("st_aa");
    set_store(32'h4, 32'hBB, 5'd4, 32'h504);
    step("st_bb");
    check("same_cycle_old", {104'd0, bus.ReadDataM}, {104'd0, 32'hAA});
    set_load(32'h4, 5'd5, 32'h508);
    step("ld_bb");
    check("next_cycle_new", {104'd0, bus.ReadDataM}, {104'd0, 32'hBB});

    // Alignment and 4 KiB wrap
    set_store(32'h1003, 32'h55, 5'd6, 32'h600);
    step("st_wrap");
    set_load(32'h0, 5'd7, 32'h604);
    step("ld_0");
    check("align_0", {104'd0, bus.ReadDataM}, {104'd0, 32'h55});
    set_load(32'h1000, 5'd7, 32'h608);
    step("ld_1000");
    check("wrap_1000", {104'd0, bus.ReadDataM}, {104'd0, 32'h55});

    // Register-0 suppression
    set_idle();
    bus.RegWriteE = 1'b1; bus.WriteRegE = 5'd0; bus.ALUOutE = 32'h44;
    step("r0");
    check("r0_regwrite", {135'd0, bus.RegWriteM}, '0);
    // jal pass-through
    set_idle();
    bus.RegWriteE = 1'b1; bus.SDtoRegE = 2'd2; bus.WriteRegE = 5'd31;
    bus.dPCE = 32'h3000; bus.dInstrE = 32'h0C000C00;
    step("jal");
    check("jal_fields", {96'd0, bus.SDtoRegM, bus.WriteRegM, bus.dPCM, bus.RegWriteM},
          {96'd0, 2'd2, 5'd31, 32'h3000, 1'b1});

    // Reset mid-operation
    set_store(32'h8, 32'h77, 5'd9, 32'h700);
    step("st_8");
    set_store(32'h8, 32'h99, 5'd9, 32'h704);
    reset = 1'b1;
    step("rst_st");
    check("rst_outputs", obs_vec(), '0);
    set_load(32'h8, 5'd10, 32'h708);
    step("ld_8");
    check("rst_mem8", {104'd0, bus.ReadDataM}, '0);
    set_load(32'h10, 5'd10, 32'h70C);
    step("ld_10_cleared");
    check("rst_mem10", {104'd0, bus.ReadDataM}, '0);

    // Random traffic over a few colliding words
    for (int n = 0; n < 60; n++) begin
      set_idle();
      bus.RegWriteE  = 1'($urandom_range(0, 1));
      bus.SDtoRegE   = 2'($urandom_range(0, 2));
      bus.MemWriteE  = 1'($urandom_range(0, 1));
      bus.ALUOutE    = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3))
                     + ($urandom_range(0, 1) == 1 ? 32'h1000 : 32'h0);
      bus.WriteDataE = $urandom;
      bus.WriteRegE  = 5'($urandom_range(0, 3));
      bus.rtE        = 5'($urandom_range(0, 3));
      bus.dPCE       = $urandom;
      bus.dInstrE    = $urandom;
      bus.WriteRegW  = 5'($urandom_range(0, 3));
      bus.RegWriteW  = 1'($urandom_range(0, 1));
      bus.ResultW    = $urandom;
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
